// File: rtl/aes_dec_ctrl.sv
// aes_dec_ctrl: round sequencer for a shared AES inverse-cipher datapath; optional blk_cnt via AES_DEC_CTRL_BLKCNT_EN
module aes_dec_ctrl #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [127:0] dp_state,
    output logic [3:0]   key_idx,
    input  logic [127:0] dp_first,
    input  logic [127:0] dp_mid,
    input  logic [127:0] dp_final,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
`ifdef AES_DEC_CTRL_BLKCNT_EN
    output logic [31:0]  blk_cnt,
`endif
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, ROUND, FINAL, HOLD} state_e;
    localparam logic [3:0] NR = 4'(Nr);
    if (Nr < 10 || Nr > 14 || !(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_param
        $error("aes_dec_ctrl: unsupported Nk/Nr");
    end
    state_e st_q, st_d;
    logic [3:0] rnd_q, rnd_d;
    logic [127:0] state_q, state_d, out_q, out_d;
    logic ov_q, ov_d;
    // in_data is consumed by the datapath (dp_first), not by the sequencer
    logic unused_in_data;
    assign unused_in_data = ^in_data;
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= IDLE;
            rnd_q   <= 4'd0;
            state_q <= '0;
            out_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            st_q    <= st_d;
            rnd_q   <= rnd_d;
            state_q <= state_d;
            out_q   <= out_d;
            ov_q    <= ov_d;
        end
    end
    always_comb begin
        st_d    = st_q;
        rnd_d   = rnd_q;
        state_d = state_q;
        out_d   = out_q;
        ov_d    = ov_q;
        key_idx = 4'd0;
        case (st_q)
            IDLE: if (in_valid) begin
                state_d = dp_first;
                rnd_d   = 4'd1;
                st_d    = ROUND;
            end
            ROUND: begin
                key_idx = rnd_q;
                state_d = dp_mid;
                if (rnd_q == NR - 4'd1) st_d = FINAL;
                else rnd_d = rnd_q + 4'd1;
            end
            FINAL: begin
                key_idx = NR;
                out_d   = dp_final;
                ov_d    = 1'b1;
                st_d    = HOLD;
            end
            HOLD: begin
                key_idx = NR;
                if (out_ready) begin
                    ov_d = 1'b0;
                    st_d = IDLE;
                end
            end
            default: st_d = IDLE;
        endcase
    end
    assign in_ready  = st_q == IDLE;
    assign busy      = st_q != IDLE;
    assign dp_state  = state_q;
    assign out_data  = out_q;
    assign out_valid = ov_q;
`ifdef AES_DEC_CTRL_BLKCNT_EN
    logic [31:0] blk_cnt_q;
    always_ff @(posedge clk) begin
        if (rst) blk_cnt_q <= '0;
        else if (ov_q && out_ready) blk_cnt_q <= blk_cnt_q + 32'd1;
    end
    assign blk_cnt = blk_cnt_q;
`endif
endmodule

// File: tb/tb_aes_dec_ctrl.sv
// tb_aes_dec_ctrl: directed bench for aes_dec_ctrl with a behavioural AES-128 inverse round datapath
module tb_aes_dec_ctrl;
    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid, busy;
    logic [127:0] in_data = '0, dp_state, dp_first, dp_mid, dp_final, out_data, ks;
    logic [3:0] key_idx;
`ifdef AES_DEC_CTRL_BLKCNT_EN
    logic [31:0] blk_cnt;
`endif
    int pass_cnt = 0, total_cnt = 0;
    logic [7:0] sb [256];
    logic [7:0] isb [256];
    logic [127:0] rk [11];

    aes_dec_ctrl #(.Nk(4), .Nr(10)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .dp_state(dp_state), .key_idx(key_idx), .dp_first(dp_first), .dp_mid(dp_mid),
        .dp_final(dp_final), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef AES_DEC_CTRL_BLKCNT_EN
        .blk_cnt(blk_cnt),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = xt(a);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [127:0] isr_isb(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = isb[s[127-8*(r+4*((c-r+4)%4)) -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] imc(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a [4];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127-8*(r+4*c) -: 8];
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = gmul(a[r], 8'h0e) ^ gmul(a[(r+1)%4], 8'h0b)
                                      ^ gmul(a[(r+2)%4], 8'h0d) ^ gmul(a[(r+3)%4], 8'h09);
        end
        return o;
    endfunction

    task automatic init_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] p, s;
            p = 8'h01;
            for (int e = 0; e < 254; e++) p = gmul(p, 8'(x));
            s = p ^ rotl(p, 1) ^ rotl(p, 2) ^ rotl(p, 3) ^ rotl(p, 4) ^ 8'h63;
            sb[x] = s;
            isb[s] = 8'(x);
        end
    endtask

    task automatic set_key(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // controller's key_idx k walks the inverse cipher, so it selects round key Nr-k
    always_comb begin
        ks       = (key_idx <= 4'd10) ? rk[10 - int'(key_idx)] : '0;
        dp_first = in_data ^ ks;
        dp_final = isr_isb(dp_state) ^ ks;
        dp_mid   = imc(isr_isb(dp_state) ^ ks);
    end

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = CT_A; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt += 6;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        if (out_data !== 128'h0) $display("FAIL reset_out_data: got %h want 0", out_data); else pass_cnt++;
        if (dp_state !== 128'h0) $display("FAIL reset_dp_state: got %h want 0", dp_state); else pass_cnt++;
        if (key_idx !== 4'd0) $display("FAIL reset_key_idx: got %0d want 0", key_idx); else pass_cnt++;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fips();
        int n;
        in_valid = 1'b1; in_data = CT_A;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL fips_accept_ready: got %b want 1", in_ready); else pass_cnt++;
        @(negedge clk);
        in_valid = 1'b0; n = 1;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total_cnt += 4;
        if (n != 11) $display("FAIL fips_latency: got %0d want 11", n); else pass_cnt++;
        if (out_data !== PT_A) $display("FAIL fips_data: got %h want %h", out_data, PT_A); else pass_cnt++;
        @(negedge clk);
        if (out_valid !== 1'b0) $display("FAIL fips_consumed: got %b want 0", out_valid); else pass_cnt++;
        if (in_ready !== 1'b1) $display("FAIL fips_idle_ready: got %b want 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_key_trace();
        in_valid = 1'b1; in_data = CT_A;
        for (int k = 0; k <= 10; k++) begin
            total_cnt++;
            if (key_idx !== k[3:0]) $display("FAIL key_trace_%0d: got %0d want %0d", k, key_idx, k); else pass_cnt++;
            @(negedge clk);
            in_data = 128'hdeadbeef_0badf00d_12345678_9abcdef0;
        end
        total_cnt += 3;
        if (out_valid !== 1'b1) $display("FAIL trace_out_valid: got %b want 1", out_valid); else pass_cnt++;
        if (out_data !== PT_A) $display("FAIL trace_busy_ignore: got %h want %h", out_data, PT_A); else pass_cnt++;
        if (key_idx !== 4'd10) $display("FAIL trace_hold_key: got %0d want 10", key_idx); else pass_cnt++;
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_data = CT_A; out_ready = 1'b1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL b2b_first_ready: got %b want 1", in_ready); else pass_cnt++;
        for (int c = 1; c <= 23; c++) begin
            @(negedge clk);
            total_cnt += 2;
            if (in_ready !== (c == 12)) $display("FAIL b2b_in_ready_c%0d: got %b want %b", c, in_ready, c == 12); else pass_cnt++;
            if (out_valid !== (c == 11 || c == 23)) $display("FAIL b2b_out_valid_c%0d: got %b want %b", c, out_valid, c == 11 || c == 23); else pass_cnt++;
            if (c == 11 || c == 23) begin
                total_cnt++;
                if (out_data !== PT_A) $display("FAIL b2b_data_c%0d: got %h want %h", c, out_data, PT_A); else pass_cnt++;
            end
            if (c == 13) in_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_hold_stall();
        int n;
        out_ready = 1'b0; in_valid = 1'b1; in_data = CT_A;
        @(negedge clk);
        in_valid = 1'b0; n = 1;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i <= 5; i++) begin
            total_cnt += 3;
            if (out_valid !== 1'b1) $display("FAIL stall_valid_%0d: got %b want 1", i, out_valid); else pass_cnt++;
            if (out_data !== PT_A) $display("FAIL stall_data_%0d: got %h want %h", i, out_data, PT_A); else pass_cnt++;
            if (in_ready !== 1'b0) $display("FAIL stall_in_ready_%0d: got %b want 0", i, in_ready); else pass_cnt++;
            if (i == 5) out_ready = 1'b1;
            @(negedge clk);
        end
        total_cnt += 2;
        if (out_valid !== 1'b0) $display("FAIL stall_release_valid: got %b want 0", out_valid); else pass_cnt++;
        if (in_ready !== 1'b1) $display("FAIL stall_release_ready: got %b want 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int n;
        logic seen;
        set_key(KEY_B);
        in_valid = 1'b1; in_data = CT_B;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (key_idx !== 4'd4) $display("FAIL rstmid_round4: got %0d want 4", key_idx); else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total_cnt += 5;
        if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b want 1", in_ready); else pass_cnt++;
        if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b want 0", out_valid); else pass_cnt++;
        if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else pass_cnt++;
        if (key_idx !== 4'd0) $display("FAIL rstmid_key_idx: got %0d want 0", key_idx); else pass_cnt++;
        if (dp_state !== 128'h0) $display("FAIL rstmid_dp_state: got %h want 0", dp_state); else pass_cnt++;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL rstmid_abandoned: got out_valid=%b want 0", seen); else pass_cnt++;
        in_valid = 1'b1; in_data = CT_B;
        @(negedge clk);
        in_valid = 1'b0; n = 1;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total_cnt += 2;
        if (n != 11) $display("FAIL rstmid_latency: got %0d want 11", n); else pass_cnt++;
        if (out_data !== PT_B) $display("FAIL rstmid_data: got %h want %h", out_data, PT_B); else pass_cnt++;
        @(negedge clk);
    endtask

`ifdef AES_DEC_CTRL_BLKCNT_EN
    task automatic test_blkcnt();
        int n;
        set_key(KEY_A);
        rst = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total_cnt++;
        if (blk_cnt !== 32'd0) $display("FAIL blkcnt_reset: got %0d want 0", blk_cnt); else pass_cnt++;
        for (int b = 0; b < 4; b++) begin
            if (b == 3) dut.blk_cnt_q = 32'hFFFF_FFFF;
            in_valid = 1'b1; in_data = CT_A;
            @(negedge clk);
            in_valid = 1'b0; n = 1;
            while (out_valid !== 1'b1 && n < 40) begin
                @(negedge clk);
                n++;
            end
            @(negedge clk);
            if (b == 2) begin
                total_cnt++;
                if (blk_cnt !== 32'd3) $display("FAIL blkcnt_three: got %0d want 3", blk_cnt); else pass_cnt++;
            end
        end
        total_cnt++;
        if (blk_cnt !== 32'd0) $display("FAIL blkcnt_wrap: got %h want 0", blk_cnt); else pass_cnt++;
    endtask
`endif

    initial begin
        init_tables();
        set_key(KEY_A);
        test_reset();
        test_fips();
        test_key_trace();
        test_back_to_back();
        test_hold_stall();
        test_reset_mid();
`ifdef AES_DEC_CTRL_BLKCNT_EN
        test_blkcnt();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/aes_dec_ctrl.md
AES_DEC_CTRL -- requirements
Module: aes_dec_ctrl

Interface
REQ-001 SHALL have parameter Nk, default 4, key length in 32-bit words (informational; no effect on sequencing).
REQ-002 SHALL have parameter Nr, default 10, number of decryption rounds; legal range 10..14.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  ciphertext block offered.
REQ-006 SHALL have port in_ready  output  1  controller can accept a block.
REQ-007 SHALL have port in_data  input  128  ciphertext block.
REQ-008 SHALL have port dp_state  output  128  current state register, fed to the shared round datapath.
REQ-009 SHALL have port key_idx  output  4  round-key index selecting the 128-bit slice of w for the datapath.
REQ-010 SHALL have port dp_first  input  128  datapath AddRoundKey(in_data, key slice) result.
REQ-011 SHALL have port dp_mid  input  128  datapath middle-round result for dp_state.
REQ-012 SHALL have port dp_final  input  128  datapath final-round result (InvShiftRows, InvSubBytes, AddRoundKey) for dp_state.
REQ-013 SHALL have port out_valid  output  1  plaintext block available.
REQ-014 SHALL have port out_ready  input  1  consumer accepts the block.
REQ-015 SHALL have port out_data  output  128  plaintext block.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement the FSM states IDLE, ROUND, FINAL and HOLD.
REQ-018 IDLE SHALL drive in_ready=1 and key_idx=0; on in_valid=1 it SHALL load dp_first into the state register, set rnd=1 and go to ROUND.
REQ-019 ROUND SHALL drive key_idx=rnd and load dp_mid each cycle; if rnd==Nr-1 it SHALL go to FINAL, else rnd SHALL increment.
REQ-020 FINAL SHALL drive key_idx=Nr, load dp_final into out_data, set out_valid=1 and go to HOLD.
REQ-021 HOLD SHALL keep out_valid=1 and out_data stable; on out_ready=1 it SHALL clear out_valid and return to IDLE.
REQ-022 in_ready SHALL be 0 in ROUND, FINAL and HOLD; no second block is accepted until the previous block is consumed.
REQ-023 Latency SHALL be exactly Nr+1 cycles from the accept edge to the first cycle with out_valid=1 (Nr=10: 11 cycles).
REQ-024 Minimum throughput SHALL be one block per Nr+2 cycles when out_ready is held at 1.
REQ-025 rnd SHALL be 4 bits wide and SHALL never exceed Nr.
REQ-026 In IDLE and HOLD, key_idx SHALL hold its driven value (IDLE: 0; HOLD: Nr) and the state register SHALL be unchanged.
REQ-027 An in_valid asserted while the controller is busy SHALL be ignored without side effects; the source must hold it.
REQ-028 The controller SHALL perform no X-checks on datapath inputs; it SHALL sample them unconditionally in the owning state.

Reset
REQ-029 When rst=1 at a clock edge, the controller SHALL enter IDLE with in_ready=1, out_valid=0, busy=0, out_data=0, state register=0, rnd=0 and key_idx=0.
REQ-030 A reset asserted in ROUND, FINAL or HOLD SHALL abandon the block; no out_valid for that block SHALL appear.
REQ-031 rst SHALL take priority over every handshake event in the same cycle.

Configuration
REQ-032 When macro AES_DEC_CTRL_BLKCNT_EN is defined, the controller SHALL add output blk_cnt (32 bits), reset to 0, incrementing by 1 on each out_valid&&out_ready cycle and wrapping from 0xFFFFFFFF to 0.
REQ-033 When AES_DEC_CTRL_BLKCNT_EN is undefined, the blk_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 The bench SHALL cover the FIPS-197 AES-128 vector: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a with key 000102..0f, accepted at cycle T -> out_valid rises at T+11 with out_data 00112233445566778899aabbccddeeff.
REQ-035 The bench SHALL cover back-to-back blocks with out_ready=1 -> second in_ready rises 12 cycles after the first accept, and both plaintexts are correct.
REQ-036 The bench SHALL cover out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0 throughout, and one transfer on release.
REQ-037 The bench SHALL cover rst pulsed at the 4th ROUND cycle -> next cycle IDLE, out_valid=0, in_ready=1, and a subsequent vector decrypts correctly.
REQ-038 The bench SHALL cover key_idx trace for Nr=10 -> 0, 1, 2, ..., 9, 10 on consecutive cycles from accept to FINAL.
REQ-039 The bench SHALL cover, with AES_DEC_CTRL_BLKCNT_EN defined, 3 completed blocks -> blk_cnt=3; and blk_cnt preloaded to 0xFFFFFFFF plus one completion -> blk_cnt=0.
